// File: rtl/facedet_pkg.sv
// Shared types and helpers for the face-detection pixel pipeline:
// pixel width default, pad pixel value, stream FSM states and ceil8.
package facedet_pkg;

    localparam int          PIX_W_DEFAULT     = 32;
    localparam logic [31:0] PAD_VALUE_DEFAULT = 32'd0;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    // Rounds v up to the next multiple of 8; one extra bit keeps the carry.
    function automatic logic [32:0] ceil8(input logic [31:0] v);
        logic [32:0] s;
        s = {1'b0, v} + 33'd7;
        return s & ~33'h7;
    endfunction

endpackage

// File: rtl/pad_xy_cnt.sv
// Raster x/y position counter with programmable column/row counts.
// eol flags the last column, eof the last column of the last row.
module pad_xy_cnt #(
    parameter int CW = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    input  logic [CW-1:0] x_limit,
    input  logic [CW-1:0] y_limit,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          eol,
    output logic          eof
);

    localparam logic [CW-1:0] ONE = CW'(1);

    assign eol = (x == x_limit - ONE);
    assign eof = eol && (y == y_limit - ONE);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= eof ? '0 : y + ONE;
            end else begin
                x <= x + ONE;
            end
        end
    end

endmodule

// File: rtl/pad8_square.sv
// Pads a raster pixel stream to an 8-aligned frame, square when the
// PAD_SQUARE_EN macro is defined, else ceil8(width) x ceil8(height).
module pad8_square
    import facedet_pkg::*;
#(
    parameter int               PIX_W     = PIX_W_DEFAULT,
    parameter int               DIM_W     = 16,
    parameter logic [PIX_W-1:0] PAD_VALUE = PIX_W'(PAD_VALUE_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_eol,
    output logic             out_eof,
    output logic [DIM_W:0]   size,
    output logic             busy,
    output logic             done
);

    localparam int SW = DIM_W + 1;

    state_t           state, state_next;
    logic [DIM_W-1:0] width_q, height_q;
    logic [SW-1:0]    cols_q, rows_q;
    logic [SW-1:0]    cols_next, rows_next;
    logic [SW-1:0]    cw, ch;
    logic [SW-1:0]    x, y;
    logic             eol, eof;
    logic             issued;
    logic             in_image;
    logic             load;
    logic             fire;
    logic             dims_ok;
    logic             accept_start;
    logic             done_next;
    logic             done_q;

    always_comb begin
        cw = SW'(ceil8(32'(width)));
        ch = SW'(ceil8(32'(height)));
`ifdef PAD_SQUARE_EN
        cols_next = (cw > ch) ? cw : ch;
        rows_next = cols_next;
`else
        cols_next = cw;
        rows_next = ch;
`endif
    end

    pad_xy_cnt #(
        .CW(SW)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept_start),
        .advance (fire),
        .x_limit (cols_q),
        .y_limit (rows_q),
        .x       (x),
        .y       (y),
        .eol     (eol),
        .eof     (eof)
    );

    // issued marks that the final position has been loaded; the frame only
    // ends once that eof pixel actually drains from the output register.
    always_comb begin
        state_next   = state;
        done_next    = 1'b0;
        in_ready     = 1'b0;
        fire         = 1'b0;
        dims_ok      = (width != '0) && (height != '0);
        accept_start = 1'b0;
        in_image     = (x < {1'b0, width_q}) && (y < {1'b0, height_q});
        load         = !out_valid || out_ready;
        case (state)
            IDLE: begin
                if (start) begin
                    if (dims_ok) begin
                        accept_start = 1'b1;
                        state_next   = STREAM;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (!issued && load) begin
                    if (in_image) begin
                        in_ready = 1'b1;
                        fire     = in_valid;
                    end else begin
                        fire = 1'b1;
                    end
                end
                if (issued && out_valid && out_ready && out_eof) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            width_q  <= '0;
            height_q <= '0;
            cols_q   <= '0;
            rows_q   <= '0;
            issued   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
            if (state == IDLE && start) begin
                if (dims_ok) begin
                    width_q  <= width;
                    height_q <= height;
                    cols_q   <= cols_next;
                    rows_q   <= rows_next;
                end else begin
                    cols_q <= '0;
                    rows_q <= '0;
                end
                issued <= 1'b0;
            end else if (fire && eof) begin
                issued <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= in_image ? in_data : PAD_VALUE;
            out_eol   <= eol;
            out_eof   <= eof;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign size = cols_q;
    assign busy = (state == STREAM);
    assign done = done_q;

endmodule

// File: tb/tb_pad8_square.sv
// Scoreboard bench for pad8_square: random pixels and handshakes against a
// frame-level model of the padded raster; honours PAD_SQUARE_EN.
module tb_pad8_square;

    localparam int          PIX_W = 32;
    localparam int          DIM_W = 16;
    localparam logic [31:0] PAD   = 32'hA5A5_5A5A;

    typedef struct packed {
        logic [31:0] d;
        logic        eol;
        logic        eof;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [DIM_W-1:0] width = '0;
    logic [DIM_W-1:0] height = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PIX_W-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PIX_W-1:0] out_data;
    logic             out_eol;
    logic             out_eof;
    logic [DIM_W:0]   size;
    logic             busy;
    logic             done;

    pad8_square #(
        .PIX_W     (PIX_W),
        .DIM_W     (DIM_W),
        .PAD_VALUE (PAD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .width     (width),
        .height    (height),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .size      (size),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        exp_q[$];
    logic [31:0] src_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    bit          in_gaps = 1'b0;
    int          out_mode = 0;
    int          out_count = 0;
    int          in_count = 0;
    int          eof_cyc = -1;
    int          exp_size = 0;
    int          exp_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Feeds queued source pixels and drives out_ready per the current mode.
    initial begin : feeder
        bit hs;
        forever begin
            @(negedge clk);
            hs = in_valid && in_ready;
            if (mon_en && out_valid && !out_ready) check("stall_no_accept", 64'(in_ready), 64'd0);
            if (hs) in_count++;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            in_valid  = (src_q.size() > 0) && (!in_gaps || ($urandom_range(3) != 0));
            in_data   = (src_q.size() > 0) ? src_q[0] : $urandom;
            out_ready = (out_mode == 0) ? 1'b1 :
                        (out_mode == 1) ? !out_ready : ($urandom_range(2) != 0);
        end
    end

    initial begin : monitor
        exp_t        e;
        bit          held;
        logic [33:0] hv;
        held = 1'b0;
        hv   = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                held = 1'b0;
                continue;
            end
            if (out_valid && !out_ready) begin
                if (held) check("held_stable", 64'({out_data, out_eol, out_eof}), 64'(hv));
                hv   = {out_data, out_eol, out_eof};
                held = 1'b1;
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0h expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", 64'({out_data, out_eol, out_eof}), 64'(e));
                end
                out_count++;
                if (out_eof) eof_cyc = cyc;
            end
        end
    end

    // Frame model straight from the padding rules: pixels in raster order,
    // pad value outside the source image, stride rounded up to 8.
    task automatic load_model(input int w, input int h);
        int          c8w, c8h, cols, rows;
        logic [31:0] p;
        c8w = ((w + 7) / 8) * 8;
        c8h = ((h + 7) / 8) * 8;
`ifdef PAD_SQUARE_EN
        cols = (c8w > c8h) ? c8w : c8h;
        rows = cols;
`else
        cols = c8w;
        rows = c8h;
`endif
        for (int yy = 0; yy < rows; yy++) begin
            for (int xx = 0; xx < cols; xx++) begin
                if (xx < w && yy < h) begin
                    p = $urandom;
                    src_q.push_back(p);
                end else begin
                    p = PAD;
                end
                exp_q.push_back(exp_t'{p, xx == cols - 1, (xx == cols - 1) && (yy == rows - 1)});
            end
        end
        exp_size = cols;
        exp_n    = cols * rows;
    endtask

    task automatic run_frame(input int w, input int h, input int mode, input bit gaps, input bit inject);
        int s_cyc;
        int done_cyc;
        bit got;
        out_mode  = mode;
        in_gaps   = gaps;
        out_count = 0;
        in_count  = 0;
        eof_cyc   = -1;
        got       = 1'b0;
        done_cyc  = 0;
        load_model(w, h);
        start  = 1'b1;
        width  = DIM_W'(w);
        height = DIM_W'(h);
        s_cyc  = cyc;
        tick();
        start  = 1'b0;
        width  = DIM_W'($urandom);
        height = DIM_W'($urandom);
        check("size_latched", 64'(size), 64'(exp_size));
        for (int k = 0; k < exp_n * 8 + 100; k++) begin
            tick();
            if (inject && k == 20) begin
                start  = 1'b1;
                width  = 16'd3;
                height = 16'd3;
            end else if (inject && k == 21) begin
                start = 1'b0;
                check("start_ignored_size", 64'(size), 64'(exp_size));
                check("start_ignored_busy", 64'(busy), 64'd1);
            end
            if (done) begin
                got      = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL frame_timeout: got no done expected done for %0dx%0d", w, h);
        end else begin
            check("done_after_eof", 64'(done_cyc), 64'(eof_cyc + 1));
            if (mode == 0 && !gaps) check("full_rate", 64'(done_cyc - s_cyc), 64'(exp_n + 2));
            check("in_consumed", 64'(in_count), 64'(w * h));
            check("out_count", 64'(out_count), 64'(exp_n));
            check("exp_drained", 64'(exp_q.size()), 64'd0);
            check("busy_at_done", 64'(busy), 64'd0);
            check("size_held", 64'(size), 64'(exp_size));
            tick();
            check("done_one_cycle", 64'(done), 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_eol_eof"}, 64'({out_eol, out_eof}), 64'd0);
        check({tag, "_size"}, 64'(size), 64'd0);
        check({tag, "_busy_done"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish by 3000000");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit hit;
        reset = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset  = 1'b1;
        mon_en = 1'b1;
        tick();

        run_frame(10, 6, 0, 1'b0, 1'b0);
        run_frame(64, 64, 0, 1'b0, 1'b0);
        run_frame(5, 20, 1, 1'b0, 1'b0);

        // Abandon a 10x6 frame at output 37.
        out_mode  = 0;
        in_gaps   = 1'b0;
        out_count = 0;
        load_model(10, 6);
        start  = 1'b1;
        width  = 16'd10;
        height = 16'd6;
        tick();
        start = 1'b0;
        hit   = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (out_count >= 37) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("reached_output_37", 64'(hit), 64'd1);
        mon_en = 1'b0;
        reset  = 1'b0;
        tick();
        check_reset_outputs("midreset");
        reset = 1'b1;
        exp_q.delete();
        src_q.delete();
        tick();
        check("no_done_after_reset", 64'(done), 64'd0);
        mon_en = 1'b1;
        tick();

        run_frame(10, 6, 0, 1'b0, 1'b1);

        // Zero dimension: done next cycle, no pixels, size cleared.
        out_mode = 0;
        start    = 1'b1;
        width    = 16'd0;
        height   = 16'd5;
        tick();
        start = 1'b0;
        check("zero_done", 64'(done), 64'd1);
        check("zero_size", 64'(size), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        tick();
        check("zero_done_pulse", 64'(done), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("zero_no_output", 64'(out_valid), 64'd0);
            tick();
        end

        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(1, 20), $urandom_range(1, 20), 2, 1'b1, i == 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
